// File: rtl/lsu_subword_ctrl_if.sv
// Core-side request/response bundle for lsu_subword_ctrl.
// Optional macro LSU_MISALIGN_TRAP_EN adds the resp_err signal.
interface lsu_subword_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
`else
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
`endif
endinterface

// File: rtl/lsu_subword_ctrl.sv
// Load/store controller in front of a word-wide, synchronous-read data memory.
// Sub-word stores are done as read-modify-write; loads are sign/zero extended.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests are
// answered immediately with resp_err and never touch memory.
module lsu_subword_ctrl #(
  parameter int unsigned MEM_RD_LAT = 1,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_subword_ctrl_if.slave bus,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [2:0] {StIdle, StRead, StRdcap, StWrite, StResp} state_e;

  localparam logic [2:0] CntLast = 3'(MEM_RD_LAT - 1);

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [1:0]        lo_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [31:0]       mem_wd_q;
  logic              mem_we_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;

  // Reserved size 11 behaves exactly like a word.
  logic [1:0] req_size_n;
  assign req_size_n = (bus.req_size == 2'b11) ? 2'b10 : bus.req_size;

`ifdef LSU_MISALIGN_TRAP_EN
  logic resp_err_q;
  logic req_misalign;
  assign req_misalign = ((req_size_n == 2'b01) && bus.req_addr[0]) ||
                        ((req_size_n == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign bus.resp_err = resp_err_q;
`endif

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] merged;
  logic [31:0] ext;

  assign byte_lane = mem_rd[{lo_q, 3'b000} +: 8];
  assign half_lane = mem_rd[{lo_q[1], 4'b0000} +: 16];

  // Lane merge for sub-word stores and lane extraction/extension for loads.
  always_comb begin
    merged = mem_rd;
    ext    = mem_rd;
    case (size_q)
      2'b00: begin
        merged[{lo_q, 3'b000} +: 8] = wdata_q[7:0];
        ext = {{24{~uns_q & byte_lane[7]}}, byte_lane};
      end
      2'b01: begin
        merged[{lo_q[1], 4'b0000} +: 16] = wdata_q;
        ext = {{16{~uns_q & half_lane[15]}}, half_lane};
      end
      default: begin
        merged = mem_rd;
        ext    = mem_rd;
      end
    endcase
  end

  // Control FSM with registered memory and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      lo_q         <= 2'b00;
      wdata_q      <= '0;
      mem_a_q      <= '0;
      mem_wd_q     <= '0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless a state below re-arms them.
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_err_q   <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            we_q         <= bus.req_we;
            size_q       <= req_size_n;
            uns_q        <= bus.req_unsigned;
            lo_q         <= bus.req_addr[1:0];
            wdata_q      <= bus.req_wdata[15:0];
            cnt_q        <= '0;
            mem_a_q      <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            resp_rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            if (req_misalign) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              state_q      <= StResp;
            end else
`endif
            if (bus.req_we && (req_size_n == 2'b10)) begin
              // Full-word store needs no read of the old word.
              mem_wd_q <= bus.req_wdata;
              mem_we_q <= 1'b1;
              state_q  <= StWrite;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          if (cnt_q == CntLast) begin
            state_q <= StRdcap;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StRdcap: begin
          if (we_q) begin
            mem_wd_q <= merged;
            mem_we_q <= 1'b1;
            state_q  <= StWrite;
          end else begin
            resp_rdata_q <= ext;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end
        end
        StWrite: begin
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign busy           = (state_q != StIdle);
  assign mem_a          = mem_a_q;
  assign mem_wd         = mem_wd_q;
  assign mem_we         = mem_we_q;

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Self-checking bench for lsu_subword_ctrl: directed cases plus randomized
// traffic against a word-array reference model and a synchronous memory.
module tb_lsu_subword_ctrl;

  localparam int unsigned L      = 1;
  localparam int unsigned ADDR_W = 32;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;
  logic        load_mem;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] ref_mem [64];
  logic [31:0] sram    [64];
  logic [31:0] rd_pipe [L];

  lsu_subword_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_subword_ctrl #(
    .MEM_RD_LAT(L),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .mem_a (mem_a),
    .mem_wd(mem_wd),
    .mem_we(mem_we),
    .mem_rd(mem_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory with L cycles of read latency.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) sram[i] <= ref_mem[i];
    end else if (mem_we) begin
      sram[mem_a[7:2]] <= mem_wd;
    end
    rd_pipe[0] <= sram[mem_a[7:2]];
    for (int i = 1; i < int'(L); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rd = rd_pipe[L-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request (called at a negedge) and check every cycle up to the response.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [7:0] a8, input logic [31:0] wd,
                        output logic [31:0] got);
    int          idx, k, sh, eff, wait_n, we_idx, resp_idx;
    logic        mis, we_seen, done;
    logic [31:0] w, mask, v, nw, exp_rd;
    idx = int'(a8[7:2]);
    k   = int'(a8[1:0]);
    eff = (sz == 2'd3) ? 2 : int'(sz);
    w   = ref_mem[idx];
    if (eff == 0) begin
      mask = 32'hFF << (8 * k);
      v    = (w >> (8 * k)) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      nw   = (w & ~mask) | ((wd & 32'hFF) << (8 * k));
    end else if (eff == 1) begin
      sh   = a8[1] ? 16 : 0;
      mask = 32'hFFFF << sh;
      v    = (w >> sh) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
      nw   = (w & ~mask) | ((wd & 32'hFFFF) << sh);
    end else begin
      v  = w;
      nw = wd;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((eff == 1) && a8[0]) || ((eff == 2) && (a8[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    if (mis) begin
      exp_rd = 0; we_idx = -1; resp_idx = 1;
    end else if (we) begin
      exp_rd = 0;
      if (eff == 2) begin we_idx = 1; resp_idx = 2; end
      else begin we_idx = int'(L) + 2; resp_idx = int'(L) + 3; end
    end else begin
      exp_rd = v; we_idx = -1; resp_idx = int'(L) + 2;
    end

    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = {24'd0, a8};
    bus.req_wdata    = wd;
    wait_n = 0;
    while (!bus.req_ready && wait_n < 8) begin
      @(negedge clk);
      wait_n++;
    end
    got = '0;
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (!mis && we) ref_mem[idx] = nw;

    we_seen = 1'b0;
    done    = 1'b0;
    for (int i = 1; i <= 16 && !done; i++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'd1);
      chk("mem_a", mem_a, {24'd0, a8[7:2], 2'b00});
      if (mem_we) begin
        if (!we_seen) chk("we_cycle", 32'(i), 32'(we_idx));
        else chk("we_pulses", 32'd2, 32'd1);
        chk("mem_wd", mem_wd, nw);
        we_seen = 1'b1;
      end
      if (bus.resp_valid) begin
        chk("resp_cycle", 32'(i), 32'(resp_idx));
        chk("resp_rdata", bus.resp_rdata, exp_rd);
        chk("ready_in_resp", 32'(bus.req_ready), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("resp_err", 32'(bus.resp_err), 32'(mis));
`endif
        got  = bus.resp_rdata;
        done = 1'b1;
      end
      // Junk on the request lines while busy must be ignored.
      bus.req_valid    = 1'($urandom);
      bus.req_we       = 1'($urandom);
      bus.req_size     = 2'($urandom);
      bus.req_unsigned = 1'($urandom);
      bus.req_addr     = $urandom;
      bus.req_wdata    = $urandom;
    end
    if (!done) chk("resp_timeout", 32'd0, 32'd1);
    if (we_idx > 0 && !we_seen) chk("we_missing", 32'd0, 32'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_quiet", {30'd0, bus.resp_valid, mem_we}, 32'd0);
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int          n;
    rst_n            = 1'b0;
    load_mem         = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[0] = 32'h80FF_7F01;
    ref_mem[8] = 32'h1122_3344;

    // Reset values.
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
`endif
    repeat (2) @(negedge clk);
    load_mem = 1'b0;
    rst_n    = 1'b1;
    idle_cycle();

    // Word store, byte store RMW, then the four directed loads.
    do_req(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEAD_BEEF, r);
    chk("sw_mem", sram[4], 32'hDEAD_BEEF);
    idle_cycle();
    do_req(1'b1, 2'b00, 1'b0, 8'h22, 32'h0000_00AA, r);
    chk("sb_merge", sram[8], 32'h11AA_3344);
    do_req(1'b0, 2'b00, 1'b0, 8'h03, 32'd0, r);
    chk("lb_3", r, 32'hFFFF_FF80);
    do_req(1'b0, 2'b00, 1'b1, 8'h03, 32'd0, r);
    chk("lbu_3", r, 32'h0000_0080);
    do_req(1'b0, 2'b01, 1'b0, 8'h00, 32'd0, r);
    chk("lh_0", r, 32'h0000_7F01);
    do_req(1'b0, 2'b01, 1'b0, 8'h02, 32'd0, r);
    chk("lh_2", r, 32'hFFFF_80FF);

    // Back-to-back: second request presented during the first one's response.
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'd0, r);
    chk("b2b_load", r, 32'hDEAD_BEEF);
    do_req(1'b1, 2'b01, 1'b0, 8'h12, 32'h0000_CAFE, r);
    chk("b2b_store", sram[4], 32'hCAFE_BEEF);
    idle_cycle();

    // Reset during the write cycle of a sub-word store.
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'b01;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h30;
    bus.req_wdata    = 32'h0000_1234;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!mem_we && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_we_seen", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_resp", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    chk("mid_rst_resp2", 32'(bus.resp_valid), 32'd0);
    rst_n = 1'b1;
    idle_cycle();
    chk("mid_rst_mem_kept", sram[12], ref_mem[12]);
    do_req(1'b0, 2'b10, 1'b0, 8'h30, 32'd0, r);

`ifdef LSU_MISALIGN_TRAP_EN
    do_req(1'b0, 2'b10, 1'b0, 8'h06, 32'd0, r);
    chk("trap_rdata", r, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 8'h04, 32'd0, r);
    chk("trap_after_ok", r, ref_mem[1]);
`else
    do_req(1'b0, 2'b10, 1'b0, 8'h06, 32'd0, r);
    chk("misaligned_word", r, ref_mem[1]);
`endif

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      do_req(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), $urandom, r);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    for (int i = 0; i < 64; i++) chk("final_mem", sram[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_subword_ctrl.md
Name: lsu_subword_ctrl

Overview:
- Load/store controller that sits directly upstream of the single-cycle processor's data memory.
- Accepts byte, halfword and word load/store requests from the core over a valid/ready handshake.
- Drives the memory's word-wide address, write-data and write-enable, and returns sign- or zero-extended load data.
- Performs sub-word stores as read-modify-write, because the memory only writes whole words and its read data is synchronous.

Parameters:
- MEM_RD_LAT, 1: cycles between the memory sampling mem_a and mem_rd becoming valid; legal range 1-4.
- ADDR_W, 32: width of the request and memory address.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores
- busy  out  1  high in any state other than IDLE
- mem_a  out  ADDR_W  word-aligned address to the data memory (bits [1:0] = 00)
- mem_wd  out  32  write word to the data memory
- mem_we  out  1  write strobe to the data memory
- mem_rd  in  32  read word from the data memory

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE.
  - resp_valid = 0, resp_rdata = 0, mem_we = 0, mem_a = 0, mem_wd = 0, busy = 0, req_ready = 1.
  - mem_we must drop immediately on reset assertion, including when reset arrives mid-write.
- Handshake:
  - req_ready = (state == IDLE).
  - A request is accepted on a rising edge where req_valid && req_ready.
  - On acceptance, addr, size, we, unsigned and wdata are latched.
  - Inputs are ignored at all other times.
  - There is no response backpressure; the core must take resp_valid when it pulses.
- States: IDLE, READ, RDCAP, WRITE, RESP.
- Transitions:
  - IDLE -> WRITE: word store.
  - IDLE -> READ: load or sub-word store.
  - READ: held for exactly MEM_RD_LAT cycles (internal counter), then -> RDCAP.
  - RDCAP: mem_rd is valid in this cycle.
    - Load: capture the extended lane into resp_rdata, -> RESP.
    - Sub-word store: register the merged word, -> WRITE.
  - WRITE: mem_we = 1 for exactly one cycle, then -> RESP.
  - RESP: resp_valid = 1 for one cycle, -> IDLE.
- mem_a outputs the latched {addr[ADDR_W-1:2], 2'b00} in every non-IDLE state.
- Lane rules:
  - Byte lane k = addr[1:0] maps to bits [8k+7:8k].
  - Halfword uses addr[1], mapping to bits [16*addr[1]+15 : 16*addr[1]].
  - Words ignore addr[1:0].
- Store merge: only the selected lane of mem_rd is replaced with the low bits of wdata; all other bits are preserved.
- Load extension: bit 7 (byte) or bit 15 (half) replicated to bit 31 unless unsigned is set.
- Latency, with acceptance edge at cycle T:
  - Word store: mem_we at T+1, resp_valid at T+2.
  - Load: resp_valid at T+MEM_RD_LAT+2.
  - Sub-word store: mem_we at T+MEM_RD_LAT+2, resp_valid at T+MEM_RD_LAT+3.
- Back-to-back requests: the earliest next acceptance is the cycle after RESP. req_valid held during RESP is not accepted until IDLE.
- Without the optional feature, misaligned halfwords (addr[0]=1) use addr[1] only, and misaligned words are forced to aligned addresses. No error is reported.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- When defined:
  - Adds output resp_err (1 bit, reset 0).
  - A halfword with addr[0]=1, or a word with addr[1:0]!=0, is accepted but goes IDLE -> RESP directly.
  - No memory access: mem_we stays 0.
  - resp_valid and resp_err are both 1 at T+1, with resp_rdata = 0.
  - resp_err is 0 on every other response.
- When not defined: the resp_err port does not exist, and misaligned requests follow the alignment rules above.

Test Plan:
- Word store at addr 0x10, data 0xDEADBEEF -> mem_a=0x10, mem_wd=0xDEADBEEF, mem_we=1 at T+1 only; resp_valid at T+2 with resp_rdata=0.
- Memory word 0x11223344 at 0x20, byte store 0xAA to addr 0x22 -> READ then RDCAP, then mem_we with mem_wd=0x11AA3344; resp_valid at T+4 (MEM_RD_LAT=1).
- Memory word 0x80FF7F01, loads: lb addr 0x3 -> 0xFFFFFF80; lbu addr 0x3 -> 0x00000080; lh addr 0x0 -> 0x00007F01; lh addr 0x2 -> 0xFFFF80FF. Each resp_valid at T+3.
- Back-to-back load and store with req_valid held high -> second request accepted only when req_ready returns at the cycle after RESP; no overlap of mem_we with the first request.
- rst_n pulsed low during WRITE of a sub-word store -> mem_we=0 immediately, state IDLE, req_ready=1, no resp_valid.
- With LSU_MISALIGN_TRAP_EN defined, word load at addr 0x6 -> resp_valid=1, resp_err=1, resp_rdata=0 at T+1, mem_we never asserted; an aligned access afterwards returns resp_err=0.
